// File: rtl/lector_fifos_salida_if.sv
// Bus bundle between the egress reader and its four output FIFOs / downstream sink.
// The slave modport is the reader side; the master modport is the FIFO/sink side.
interface lector_fifos_salida_if #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int CNT_WIDTH      = 8
);
  logic                      empty_p0, empty_p1, empty_p2, empty_p3;
  logic [FIFO_WORD_SIZE-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic                      out_ready;
  logic                      pop_p0, pop_p1, pop_p2, pop_p3;
  logic [FIFO_WORD_SIZE-1:0] data_out;
  logic                      valid_out;
  logic [CNT_WIDTH-1:0]      cnt_p0, cnt_p1, cnt_p2, cnt_p3;
  logic                      idle;

  modport slave (
    input  empty_p0, empty_p1, empty_p2, empty_p3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  out_ready,
    output pop_p0, pop_p1, pop_p2, pop_p3,
    output data_out, valid_out,
    output cnt_p0, cnt_p1, cnt_p2, cnt_p3,
    output idle
  );

  modport master (
    output empty_p0, empty_p1, empty_p2, empty_p3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output out_ready,
    input  pop_p0, pop_p1, pop_p2, pop_p3,
    input  data_out, valid_out,
    input  cnt_p0, cnt_p1, cnt_p2, cnt_p3,
    input  idle
  );
endinterface

// File: rtl/lector_fifos_salida.sv
// Egress reader: round-robin pops of four 1-cycle-latency FIFOs into a 2-entry
// skid buffer driving one valid/ready channel, with per-port word counters.
module lector_fifos_salida #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  lector_fifos_salida_if.slave bus
);

  logic [1:0]                r_occ;
  logic                      r_infl;
  logic [1:0]                r_infl_port;
  logic [1:0]                r_rr;
  logic [FIFO_WORD_SIZE-1:0] r_buf0;
  logic [FIFO_WORD_SIZE-1:0] r_buf1;
  logic [CNT_WIDTH-1:0]      r_cnt [4];

  logic [3:0]                w_empty;
  logic [FIFO_WORD_SIZE-1:0] w_din [4];
  logic [FIFO_WORD_SIZE-1:0] w_cap;
  logic                      w_valid;
  logic                      w_xfer;
  logic [2:0]                w_load;
  logic                      w_room;
  logic                      w_sel_any;
  logic [1:0]                w_sel_port;
  logic [1:0]                w_idx;
  logic [3:0]                w_pop;

  assign w_empty = {bus.empty_p3, bus.empty_p2, bus.empty_p1, bus.empty_p0};
  assign w_din[0] = bus.data_in_0;
  assign w_din[1] = bus.data_in_1;
  assign w_din[2] = bus.data_in_2;
  assign w_din[3] = bus.data_in_3;
  assign w_cap    = w_din[r_infl_port];

  assign w_valid = (r_occ != 2'd0);
  assign w_xfer  = w_valid && bus.out_ready;

  // Count the word already in flight so a third word is never requested.
  assign w_load = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_xfer};
  assign w_room = (w_load < 3'd2);

  always_comb begin
    w_sel_any  = 1'b0;
    w_sel_port = 2'd0;
    w_idx      = 2'd0;
    if (w_room) begin
      for (int i = 0; i < 4; i++) begin
        w_idx = r_rr + 2'(i);
        if (!w_sel_any && !w_empty[w_idx]) begin
          w_sel_any  = 1'b1;
          w_sel_port = w_idx;
        end
      end
    end
  end

  assign w_pop = (w_sel_any && reset_L) ? (4'b0001 << w_sel_port) : 4'b0000;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_infl      <= 1'b0;
      r_infl_port <= 2'd0;
      r_rr        <= 2'd0;
    end else if (w_sel_any) begin
      r_infl      <= 1'b1;
      r_infl_port <= w_sel_port;
      r_rr        <= w_sel_port + 2'd1;
    end else begin
      r_infl      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({r_infl, w_xfer})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= w_cap;
          else               r_buf1 <= w_cap;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= w_cap;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_cap;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else if (r_infl) begin
      r_cnt[r_infl_port] <= r_cnt[r_infl_port] + CNT_WIDTH'(1);
    end
  end

  assign bus.pop_p0    = w_pop[0];
  assign bus.pop_p1    = w_pop[1];
  assign bus.pop_p2    = w_pop[2];
  assign bus.pop_p3    = w_pop[3];
  assign bus.valid_out = w_valid;
  assign bus.data_out  = w_valid ? r_buf0 : '0;
  assign bus.cnt_p0    = r_cnt[0];
  assign bus.cnt_p1    = r_cnt[1];
  assign bus.cnt_p2    = r_cnt[2];
  assign bus.cnt_p3    = r_cnt[3];
  assign bus.idle      = (r_occ == 2'd0) && !r_infl && (&w_empty);

endmodule

// File: tb/tb_lector_fifos_salida.sv
// Directed bench for lector_fifos_salida: behavioural 1-cycle-latency FIFO models
// feed the reader; a second instance with 2-bit counters checks counter wrap.
module tb_lector_fifos_salida;

  logic clk;
  logic reset_L;
  int   n_tests;
  int   n_fail;

  lector_fifos_salida_if #(.FIFO_WORD_SIZE(10), .CNT_WIDTH(8)) ifc ();
  lector_fifos_salida_if #(.FIFO_WORD_SIZE(10), .CNT_WIDTH(2)) ifc2 ();

  lector_fifos_salida #(.FIFO_WORD_SIZE(10), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_L(reset_L), .bus(ifc.slave));
  lector_fifos_salida #(.FIFO_WORD_SIZE(10), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset_L(reset_L), .bus(ifc2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models
  logic [9:0] mem [4][32];
  int         rd [4];
  int         wr [4];
  logic [9:0] din [4];
  logic [3:0] popv;
  logic       out_ready;

  initial begin
    for (int k = 0; k < 4; k++) begin rd[k] = 0; wr[k] = 0; din[k] = '0; end
  end

  assign popv = {ifc.pop_p3, ifc.pop_p2, ifc.pop_p1, ifc.pop_p0};
  assign ifc.empty_p0 = (wr[0] == rd[0]);
  assign ifc.empty_p1 = (wr[1] == rd[1]);
  assign ifc.empty_p2 = (wr[2] == rd[2]);
  assign ifc.empty_p3 = (wr[3] == rd[3]);
  assign ifc.data_in_0 = din[0];
  assign ifc.data_in_1 = din[1];
  assign ifc.data_in_2 = din[2];
  assign ifc.data_in_3 = din[3];
  assign ifc.out_ready = out_ready;

  assign ifc2.empty_p0 = ifc.empty_p0;
  assign ifc2.empty_p1 = ifc.empty_p1;
  assign ifc2.empty_p2 = ifc.empty_p2;
  assign ifc2.empty_p3 = ifc.empty_p3;
  assign ifc2.data_in_0 = din[0];
  assign ifc2.data_in_1 = din[1];
  assign ifc2.data_in_2 = din[2];
  assign ifc2.data_in_3 = din[3];
  assign ifc2.out_ready = out_ready;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (popv[k]) begin
        din[k] <= mem[k][rd[k] & 31];
        rd[k]  <= rd[k] + 1;
      end
    end
  end

  // Protocol invariants checked every cycle
  always @(negedge clk) begin
    if ($countones(popv) > 1) begin
      $display("FAIL onehot_pop: pop=%b, required at most one bit", popv); n_fail++;
    end
    for (int k = 0; k < 4; k++)
      if (popv[k] && (wr[k] == rd[k])) begin
        $display("FAIL pop_empty: pop_p%0d=1 with FIFO empty, required 0", k); n_fail++;
      end
    if (reset_L && dut.r_occ == 2'd2 && dut.r_infl && !(ifc.valid_out && out_ready)) begin
      $display("FAIL overflow: capture into full buffer, required no capture"); n_fail++;
    end
  end

  task automatic push(input int k, input logic [9:0] w);
    mem[k][wr[k] & 31] = w;
    wr[k] = wr[k] + 1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) wr[k] = rd[k];
    repeat (2) cyc();
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    mid();
    n_tests++;
    if ({ifc.valid_out, ifc.data_out, popv, ifc.idle} !== {1'b0, 10'h000, 4'b0000, 1'b1}) begin
      $display("FAIL reset_outputs: valid=%b data=%h pop=%b idle=%b, required 0 000 0000 1",
               ifc.valid_out, ifc.data_out, popv, ifc.idle); n_fail++;
    end
    n_tests++;
    if ({ifc.cnt_p0, ifc.cnt_p1, ifc.cnt_p2, ifc.cnt_p3} !== 32'h0) begin
      $display("FAIL reset_counters: cnt=%h, required 00000000",
               {ifc.cnt_p0, ifc.cnt_p1, ifc.cnt_p2, ifc.cnt_p3}); n_fail++;
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2, 10'h2AA);
    mid();
    n_tests++;
    if (popv !== 4'b0100) begin
      $display("FAIL rmid_pop2: pop=%b, required 0100", popv); n_fail++;
    end
    cyc();
    reset_L = 1'b0;
    push(1, 10'h111);
    push(3, 10'h333);
    mid();
    n_tests++;
    if (popv !== 4'b0000) begin
      $display("FAIL rmid_pop_in_reset: pop=%b, required 0000", popv); n_fail++;
    end
    cyc();
    reset_L = 1'b1;
    mid();
    n_tests++;
    if ({ifc.valid_out, ifc.cnt_p2} !== {1'b0, 8'd0}) begin
      $display("FAIL rmid_discard: valid=%b cnt_p2=%0d, required 0 0", ifc.valid_out, ifc.cnt_p2);
      n_fail++;
    end
    n_tests++;
    if (popv !== 4'b0010) begin
      $display("FAIL rmid_rr_cleared: pop=%b, required 0010", popv); n_fail++;
    end
    repeat (8) cyc();
    mid();
    n_tests++;
    if ({ifc.cnt_p1, ifc.cnt_p2, ifc.cnt_p3} !== {8'd1, 8'd0, 8'd1}) begin
      $display("FAIL rmid_counts: cnt1=%0d cnt2=%0d cnt3=%0d, required 1 0 1",
               ifc.cnt_p1, ifc.cnt_p2, ifc.cnt_p3); n_fail++;
    end
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    push(1, 10'h1A5);
    mid();
    n_tests++;
    if (popv !== 4'b0010) begin
      $display("FAIL single_pop: pop=%b, required 0010", popv); n_fail++;
    end
    cyc(); mid();
    n_tests++;
    if (ifc.valid_out !== 1'b0) begin
      $display("FAIL single_latency: valid in cycle 1=%b, required 0", ifc.valid_out); n_fail++;
    end
    cyc(); mid();
    n_tests++;
    if ({ifc.valid_out, ifc.data_out, ifc.cnt_p1} !== {1'b1, 10'h1A5, 8'd1}) begin
      $display("FAIL single_out: valid=%b data=%h cnt_p1=%0d, required 1 1a5 1",
               ifc.valid_out, ifc.data_out, ifc.cnt_p1); n_fail++;
    end
    cyc(); mid();
    n_tests++;
    if ({ifc.valid_out, ifc.idle} !== 2'b01) begin
      $display("FAIL single_idle: valid=%b idle=%b, required 0 1", ifc.valid_out, ifc.idle); n_fail++;
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_w;
    logic [3:0] exp_p;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) push(k, {2'b00, 4'(k), 4'(j)});
    for (int c = 0; c < 16; c++) begin
      mid();
      exp_p = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_tests++;
      if (popv !== exp_p) begin
        $display("FAIL rr_pop c%0d: pop=%b, required %b", c, popv, exp_p); n_fail++;
      end
      if (c >= 2 && c < 14) begin
        exp_w = {2'b00, 4'((c - 2) % 4), 4'((c - 2) / 4)};
        n_tests++;
        if ({ifc.valid_out, ifc.data_out} !== {1'b1, exp_w}) begin
          $display("FAIL rr_out c%0d: valid=%b data=%h, required 1 %h",
                   c, ifc.valid_out, ifc.data_out, exp_w); n_fail++;
        end
      end
      cyc();
    end
    mid();
    n_tests++;
    if ({ifc.cnt_p0, ifc.cnt_p1, ifc.cnt_p2, ifc.cnt_p3, ifc.idle} !== {32'h03030303, 1'b1}) begin
      $display("FAIL rr_counts: cnt=%h idle=%b, required 03030303 1",
               {ifc.cnt_p0, ifc.cnt_p1, ifc.cnt_p2, ifc.cnt_p3}, ifc.idle); n_fail++;
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int         npop;
    int         nout;
    logic [9:0] exp_q [8];
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) begin
        push(k, 10'h200 | {2'b00, 4'(k), 4'(j)});
        exp_q[j * 4 + k] = 10'h200 | {2'b00, 4'(k), 4'(j)};
      end
    npop = 0;
    for (int c = 0; c < 6; c++) begin
      mid();
      npop += $countones(popv);
      if (c >= 2) begin
        n_tests++;
        if ({ifc.valid_out, ifc.data_out} !== {1'b1, 10'h200}) begin
          $display("FAIL bp_stable c%0d: valid=%b data=%h, required 1 200",
                   c, ifc.valid_out, ifc.data_out); n_fail++;
        end
      end
      cyc();
    end
    n_tests++;
    if (npop != 2 || dut.r_occ !== 2'd2) begin
      $display("FAIL bp_pops: pops=%0d occ=%0d, required 2 2", npop, dut.r_occ); n_fail++;
    end
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 30; c++) begin
      mid();
      if (ifc.valid_out) begin
        n_tests++;
        if (nout >= 8 || ifc.data_out !== exp_q[nout & 7]) begin
          $display("FAIL bp_order #%0d: data=%h, required %h", nout, ifc.data_out, exp_q[nout & 7]);
          n_fail++;
        end
        nout++;
      end
      cyc();
    end
    n_tests++;
    if (nout != 8 || ifc.idle !== 1'b1) begin
      $display("FAIL bp_count: words=%0d idle=%b, required 8 1", nout, ifc.idle); n_fail++;
    end
  endtask

  task automatic test_skip_empty();
    logic [9:0] got [$];
    do_reset();
    push(0, 10'h005);
    repeat (5) cyc();
    push(3, 10'h3C3);
    push(0, 10'h0C0);
    mid();
    n_tests++;
    if (popv !== 4'b1000) begin
      $display("FAIL skip_first: pop=%b, required 1000", popv); n_fail++;
    end
    cyc(); mid();
    n_tests++;
    if (popv !== 4'b0001) begin
      $display("FAIL skip_second: pop=%b, required 0001", popv); n_fail++;
    end
    for (int c = 0; c < 6; c++) begin
      mid();
      if (ifc.valid_out) got.push_back(ifc.data_out);
      cyc();
    end
    n_tests++;
    if (got.size() != 2 || got[0] !== 10'h3C3 || got[1] !== 10'h0C0) begin
      $display("FAIL skip_order: n=%0d first=%h, required 2 3c3 then 0c0",
               got.size(), (got.size() > 0) ? got[0] : 10'h000); n_fail++;
    end
    n_tests++;
    if (dut.r_rr !== 2'd1) begin
      $display("FAIL skip_rr: rr=%0d, required 1", dut.r_rr); n_fail++;
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int j = 0; j < 5; j++) push(2, 10'h120 | 10'(j));
    repeat (12) cyc();
    mid();
    n_tests++;
    if (ifc2.cnt_p2 !== 2'd1) begin
      $display("FAIL wrap_cnt2: cnt_p2=%0d, required 1", ifc2.cnt_p2); n_fail++;
    end
    n_tests++;
    if (ifc.cnt_p2 !== 8'd5) begin
      $display("FAIL wrap_cnt8: cnt_p2=%0d, required 5", ifc.cnt_p2); n_fail++;
    end
    cyc();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_L   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_reset_mid();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_empty();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
